// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg -- shared definitions for the PC sequencer slice.
//
// Holds the sequencer state encoding, decoded request-kind codes, the
// next-PC mux select codes, return-stack operation codes and fault codes.
// Imported by pc_sequencer and rstack_depth_tracker.
//
// Optional build macro affecting this slice: PC_SEQ_PERF_EN (see pc_sequencer).

package pc_seq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_FILL   = 3'd0,
    ST_DECODE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_HALT   = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  // Decoded control-flow request kinds
  localparam logic [2:0] KIND_SEQ    = 3'd0;
  localparam logic [2:0] KIND_BR_T   = 3'd1;
  localparam logic [2:0] KIND_BR_NT  = 3'd2;
  localparam logic [2:0] KIND_JUMP   = 3'd3;
  localparam logic [2:0] KIND_CALL   = 3'd4;
  localparam logic [2:0] KIND_RET    = 3'd5;
  localparam logic [2:0] KIND_HALT   = 3'd6;
  localparam logic [2:0] KIND_RSVD   = 3'd7;

  // Next-PC mux select codes
  localparam logic [2:0] SEL_RSTACK  = 3'd0;
  localparam logic [2:0] SEL_BRANCH  = 3'd1;
  localparam logic [2:0] SEL_JUMP    = 3'd2;
  localparam logic [2:0] SEL_INCR    = 3'd4;

  // Return-stack operations
  localparam logic [1:0] RS_HOLD     = 2'b00;
  localparam logic [1:0] RS_PUSH     = 2'b01;
  localparam logic [1:0] RS_POP      = 2'b10;

  // Fault codes
  localparam logic [1:0] FC_NONE      = 2'b00;
  localparam logic [1:0] FC_OVERFLOW  = 2'b01;
  localparam logic [1:0] FC_UNDERFLOW = 2'b10;
  localparam logic [1:0] FC_ILLEGAL   = 2'b11;

  // Mux select for the kinds that redirect the PC without touching the
  // return stack; everything else falls through to PC+2.
  function automatic logic [2:0] plain_target_sel(input logic [2:0] kind);
    logic [2:0] sel;
    sel = SEL_INCR;
    if (kind == KIND_BR_T) sel = SEL_BRANCH;
    else if (kind == KIND_JUMP) sel = SEL_JUMP;
    return sel;
  endfunction

endpackage

// File: rtl/rstack_depth_tracker.sv
// rstack_depth_tracker -- return-stack occupancy counter.
//
// Ports:
//   CLK    in   clock, rising edge
//   Reset  in   asynchronous active-low reset (depth -> 0)
//   push   in   one entry is written this cycle
//   pop    in   one entry is removed this cycle
//   depth  out  current occupancy (0..RSTACK_DEPTH)
//   full   out  depth == RSTACK_DEPTH
//   empty  out  depth == 0
//
// The counter saturates at both ends so a stray push when full or pop when
// empty can never wrap it; the sequencer refuses those requests anyway.

module rstack_depth_tracker
  import pc_seq_pkg::*;
#(
  parameter int RSTACK_DEPTH = 16,
  parameter int DEPTH_W      = 5
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               push,
  input  logic               pop,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(RSTACK_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

  logic [DEPTH_W-1:0] depth_reg;
  logic [DEPTH_W-1:0] depth_next;

  always_comb begin
    depth_next = depth_reg;
    if (push && !pop && (depth_reg != DEPTH_MAX))
      depth_next = depth_reg + DEPTH_ONE;
    else if (pop && !push && (depth_reg != '0))
      depth_next = depth_reg - DEPTH_ONE;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) depth_reg <= '0;
    else        depth_reg <= depth_next;
  end

  assign depth = depth_reg;
  assign full  = (depth_reg == DEPTH_MAX);
  assign empty = (depth_reg == '0);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer -- control FSM for the PC-update datapath.
//
// Accepts one decoded control-flow request per instruction and issues, in
// the same cycle, the PC write enable, next-PC mux select and return-stack
// operation. A WAIT cycle after each accepted request covers the one-cycle
// synchronous instruction-memory read of the new PC.
//
// Ports:
//   CLK           in   clock, rising edge
//   Reset         in   asynchronous active-low reset
//   stall         in   pipeline hold; blocks request acceptance
//   req_valid     in   decoder presents a request
//   req_kind      in   request kind (see pc_seq_pkg KIND_*)
//   req_ready     out  request can be accepted this cycle
//   pc_write      out  PC register write enable
//   pc_control    out  next-PC mux select (SEL_*)
//   rstack_op     out  return-stack operation (RS_*)
//   fetch_en      out  instruction-memory read enable
//   rstack_depth  out  return-stack occupancy
//   halted        out  HALT reached (sticky until reset)
//   fault         out  FAULT reached (sticky until reset)
//   fault_code    out  FC_* code of the fault
//
// Build macro PC_SEQ_PERF_EN adds:
//   retired_cnt   out  16-bit count of retired (non-fault, non-HALT) requests
//   stall_cnt     out  16-bit count of DECODE cycles with stall asserted

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int RSTACK_DEPTH = 16,
  parameter int DEPTH_W      = 5
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               stall,
  input  logic               req_valid,
  input  logic [2:0]         req_kind,
  output logic               req_ready,
  output logic               pc_write,
  output logic [2:0]         pc_control,
  output logic [1:0]         rstack_op,
  output logic               fetch_en,
  output logic [DEPTH_W-1:0] rstack_depth,
  output logic               halted,
  output logic               fault,
  output logic [1:0]         fault_code
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [15:0]        retired_cnt,
  output logic [15:0]        stall_cnt
`endif
);

  state_t     state_reg, state_next;
  logic [1:0] fault_code_reg, fault_code_next;

  logic       pc_write_c;
  logic [2:0] pc_control_c;
  logic [1:0] rstack_op_c;
  logic       fetch_en_c;
  logic       req_ready_c;

  logic       rs_full;
  logic       rs_empty;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_reg      <= ST_FILL;
      fault_code_reg <= FC_NONE;
    end else begin
      state_reg      <= state_next;
      fault_code_reg <= fault_code_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next state and Mealy outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    fault_code_next = fault_code_reg;
    pc_write_c      = 1'b0;
    pc_control_c    = SEL_INCR;
    rstack_op_c     = RS_HOLD;
    fetch_en_c      = 1'b0;
    req_ready_c     = 1'b0;

    case (state_reg)
      ST_FILL: begin
        // Fetch of address 0 is in flight; nothing can be decoded yet.
        fetch_en_c = 1'b1;
        state_next = ST_DECODE;
      end

      ST_DECODE: begin
        fetch_en_c  = 1'b1;
        req_ready_c = !stall;
        if (req_valid && !stall) begin
          case (req_kind)
            KIND_SEQ, KIND_BR_NT, KIND_BR_T, KIND_JUMP: begin
              pc_write_c   = 1'b1;
              pc_control_c = plain_target_sel(req_kind);
              state_next   = ST_WAIT;
            end
            KIND_CALL: begin
              if (rs_full) begin
                state_next      = ST_FAULT;
                fault_code_next = FC_OVERFLOW;
              end else begin
                pc_write_c   = 1'b1;
                pc_control_c = SEL_JUMP;
                rstack_op_c  = RS_PUSH;
                state_next   = ST_WAIT;
              end
            end
            KIND_RET: begin
              if (rs_empty) begin
                state_next      = ST_FAULT;
                fault_code_next = FC_UNDERFLOW;
              end else begin
                // PC takes the current top at the same edge the pop retires it.
                pc_write_c   = 1'b1;
                pc_control_c = SEL_RSTACK;
                rstack_op_c  = RS_POP;
                state_next   = ST_WAIT;
              end
            end
            KIND_HALT: begin
              state_next = ST_HALT;
            end
            default: begin
              state_next      = ST_FAULT;
              fault_code_next = FC_ILLEGAL;
            end
          endcase
        end
      end

      ST_WAIT: begin
        // Memory is reading the freshly written PC.
        fetch_en_c = 1'b1;
        state_next = ST_DECODE;
      end

      ST_HALT, ST_FAULT: begin
        // Terminal until reset; all outputs stay at their defaults.
      end

      default: begin
        state_next = ST_FILL;
      end
    endcase
  end

  // Mealy outputs are forced low while reset is held so that no partial
  // push or pop can leak out of a cycle that reset interrupts.
  assign pc_write   = Reset & pc_write_c;
  assign pc_control = Reset ? pc_control_c : 3'd0;
  assign rstack_op  = Reset ? rstack_op_c  : RS_HOLD;
  assign fetch_en   = Reset & fetch_en_c;
  assign req_ready  = Reset & req_ready_c;

  assign halted     = (state_reg == ST_HALT);
  assign fault      = (state_reg == ST_FAULT);
  assign fault_code = fault_code_reg;

  // ---------------------------------------------------------------------
  // Return-stack depth
  // ---------------------------------------------------------------------
  rstack_depth_tracker #(
    .RSTACK_DEPTH (RSTACK_DEPTH),
    .DEPTH_W      (DEPTH_W)
  ) u_depth (
    .CLK   (CLK),
    .Reset (Reset),
    .push  (rstack_op_c == RS_PUSH),
    .pop   (rstack_op_c == RS_POP),
    .depth (rstack_depth),
    .full  (rs_full),
    .empty (rs_empty)
  );

`ifdef PC_SEQ_PERF_EN
  // ---------------------------------------------------------------------
  // Performance counters (wrap modulo 2^16)
  // ---------------------------------------------------------------------
  logic [15:0] retired_cnt_reg;
  logic [15:0] stall_cnt_reg;

  // A request retires exactly when DECODE hands over to WAIT.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      retired_cnt_reg <= '0;
      stall_cnt_reg   <= '0;
    end else begin
      if ((state_reg == ST_DECODE) && (state_next == ST_WAIT))
        retired_cnt_reg <= retired_cnt_reg + 16'd1;
      if ((state_reg == ST_DECODE) && stall)
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign retired_cnt = retired_cnt_reg;
  assign stall_cnt   = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- self-checking bench for pc_sequencer.
//
// Inputs are driven on the falling edge; outputs are sampled 2 ns later,
// well before the next rising edge. A behavioural model tracks the
// sequencer phase, stack depth and fault code from the request rules and
// produces the expected output vector for every sampled cycle.

module tb_pc_sequencer;

  localparam int RSD = 16;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic       stall = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_kind = 3'd0;

  logic       req_ready;
  logic       pc_write;
  logic [2:0] pc_control;
  logic [1:0] rstack_op;
  logic       fetch_en;
  logic [4:0] rstack_depth;
  logic       halted;
  logic       fault;
  logic [1:0] fault_code;
`ifdef PC_SEQ_PERF_EN
  logic [15:0] retired_cnt;
  logic [15:0] stall_cnt;
`endif

  pc_sequencer #(.RSTACK_DEPTH(RSD), .DEPTH_W(5)) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .stall        (stall),
    .req_valid    (req_valid),
    .req_kind     (req_kind),
    .req_ready    (req_ready),
    .pc_write     (pc_write),
    .pc_control   (pc_control),
    .rstack_op    (rstack_op),
    .fetch_en     (fetch_en),
    .rstack_depth (rstack_depth),
    .halted       (halted),
    .fault        (fault),
    .fault_code   (fault_code)
`ifdef PC_SEQ_PERF_EN
    ,
    .retired_cnt  (retired_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // ---------------- behavioural model ----------------
  // phase: 0 fetching first word, 1 ready for a request, 2 waiting on
  // memory, 3 halted, 4 faulted
  int m_phase, m_depth, m_code, m_retired, m_stalls;
  int n_phase, n_depth, n_code;
  bit n_retire, n_stall;
  logic [16:0] exp_vec;

  task automatic model_reset();
    m_phase = 0; m_depth = 0; m_code = 0; m_retired = 0; m_stalls = 0;
  endtask

  task automatic model_eval();
    logic w; logic [2:0] sel; logic [1:0] op; logic fe, rdy;
    w = 0; sel = 3'd4; op = 2'b00; fe = 0; rdy = 0;
    n_phase = m_phase; n_depth = m_depth; n_code = m_code;
    n_retire = 0; n_stall = 0;
    if (m_phase == 0 || m_phase == 2) begin
      fe = 1; n_phase = 1;
    end else if (m_phase == 1) begin
      fe = 1; rdy = !stall; n_stall = stall;
      if (req_valid && !stall) begin
        n_phase = 2;
        case (int'(req_kind))
          0, 2: begin w = 1; sel = 3'd4; end
          1:    begin w = 1; sel = 3'd1; end
          3:    begin w = 1; sel = 3'd2; end
          4: if (m_depth < RSD) begin w = 1; sel = 3'd2; op = 2'b01; n_depth = m_depth + 1; end
             else begin n_phase = 4; n_code = 1; end
          5: if (m_depth > 0) begin w = 1; sel = 3'd0; op = 2'b10; n_depth = m_depth - 1; end
             else begin n_phase = 4; n_code = 2; end
          6: n_phase = 3;
          default: begin n_phase = 4; n_code = 3; end
        endcase
        n_retire = (n_phase == 2);
      end
    end
    exp_vec = {w, sel, op, fe, rdy, 5'(m_depth), (m_phase == 3), (m_phase == 4), 2'(m_code)};
  endtask

  task automatic model_commit();
    m_phase = n_phase; m_depth = n_depth; m_code = n_code;
    m_retired += int'(n_retire); m_stalls += int'(n_stall);
  endtask

  function automatic logic [16:0] obs();
    return {pc_write, pc_control, rstack_op, fetch_en, req_ready,
            rstack_depth, halted, fault, fault_code};
  endfunction

  // Drive one cycle of inputs and compute the expected outputs for it.
  task automatic drive(input bit s, input bit v, input int k);
    @(negedge CLK);
    stall = s; req_valid = v; req_kind = 3'(k); cyc++;
    #2;
    model_eval();
  endtask

  // Reset asserted at a falling edge, released 1 ns after the following
  // rising edge so the next sampled cycle is the first-fetch cycle.
  task automatic apply_reset();
    @(negedge CLK);
    Reset = 0; stall = 0; req_valid = 0;
    model_reset();
    @(posedge CLK);
    #1 Reset = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 0; stall = 0; req_valid = 1; req_kind = 3'd4;
    model_reset();
    repeat (2) @(negedge CLK);
    #2;
    checks++;
    if ({pc_write, rstack_op, fetch_en, req_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000", {pc_write, rstack_op, fetch_en, req_ready});
    end
    checks++;
    if ({rstack_depth, halted, fault, fault_code} !== 9'b0) begin
      errors++;
      $display("FAIL reset_state: got %b want 000000000", {rstack_depth, halted, fault, fault_code});
    end
    @(posedge CLK); #1 Reset = 1;
    drive(0, 1, 0);
    checks++;
    if (obs() !== exp_vec) begin
      errors++; $display("FAIL reset_fill cyc%0d: got %b want %b", cyc, obs(), exp_vec);
    end
    model_commit();
  endtask

  task automatic test_seq_stream();
    int writes;
    apply_reset();
    writes = 0;
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, 0);
      writes += int'(pc_write);
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL seq_stream cyc%0d: got %b want %b", cyc, obs(), exp_vec);
      end
      model_commit();
    end
    // fill, then accept/wait pairs: 4 writes over 9 cycles
    checks++;
    if (writes !== 4) begin
      errors++; $display("FAIL seq_stream_count: got %0d want 4", writes);
    end
  endtask

  task automatic test_call_ret();
    int kinds[3] = '{4, 4, 5};
    apply_reset();
    drive(0, 0, 0); model_commit();
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 2; j++) begin
        drive(0, 1, kinds[i]);
        checks++;
        if (obs() !== exp_vec) begin
          errors++; $display("FAIL call_ret cyc%0d: got %b want %b", cyc, obs(), exp_vec);
        end
        model_commit();
      end
    end
    checks++;
    if (rstack_depth !== 5'd1) begin
      errors++; $display("FAIL call_ret_depth: got %0d want 1", rstack_depth);
    end
  endtask

  task automatic test_ret_underflow();
    apply_reset();
    drive(0, 0, 0); model_commit();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 5);
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL ret_underflow cyc%0d: got %b want %b", cyc, obs(), exp_vec);
      end
      model_commit();
    end
    checks++;
    if ({fault, fault_code, fetch_en, pc_write} !== 5'b11000) begin
      errors++; $display("FAIL ret_underflow_final: got %b want 11000", {fault, fault_code, fetch_en, pc_write});
    end
  endtask

  task automatic test_call_overflow();
    apply_reset();
    drive(0, 0, 0); model_commit();
    for (int i = 0; i < 2 * (RSD + 1) + 2; i++) begin
      drive(0, 1, 4);
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL call_overflow cyc%0d: got %b want %b", cyc, obs(), exp_vec);
      end
      model_commit();
    end
    checks++;
    if ({rstack_depth, fault, fault_code} !== {5'd16, 1'b1, 2'b01}) begin
      errors++; $display("FAIL call_overflow_final: got depth=%0d fault=%b code=%b want 16 1 01",
                         rstack_depth, fault, fault_code);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    drive(0, 0, 0); model_commit();
    for (int i = 0; i < 5; i++) begin
      drive(i < 3, 1, 3);
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL stall cyc%0d: got %b want %b", cyc, obs(), exp_vec);
      end
      model_commit();
    end
`ifdef PC_SEQ_PERF_EN
    checks++;
    if (stall_cnt !== 16'd3) begin
      errors++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt);
    end
`endif
  endtask

  task automatic test_reset_in_wait();
    apply_reset();
    drive(0, 0, 0); model_commit();
    drive(0, 1, 4); model_commit();
    @(posedge CLK);
    #1 Reset = 0;
    model_reset();
    #1;
    checks++;
    if ({pc_write, rstack_op, fetch_en, req_ready, rstack_depth} !== 10'b0) begin
      errors++; $display("FAIL reset_in_wait: got %b want 0000000000",
                         {pc_write, rstack_op, fetch_en, req_ready, rstack_depth});
    end
    @(posedge CLK); #1 Reset = 1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1);
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL reset_in_wait_after cyc%0d: got %b want %b", cyc, obs(), exp_vec);
      end
      model_commit();
    end
  endtask

  task automatic test_halt();
    apply_reset();
    drive(0, 0, 0); model_commit();
    drive(0, 1, 6);
    checks++;
    if (obs() !== exp_vec) begin
      errors++; $display("FAIL halt_accept cyc%0d: got %b want %b", cyc, obs(), exp_vec);
    end
    model_commit();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0);
      checks++;
      if (obs() !== exp_vec || halted !== 1'b1) begin
        errors++; $display("FAIL halt_hold cyc%0d: got %b want %b", cyc, obs(), exp_vec);
      end
      model_commit();
    end
  endtask

  task automatic test_random();
    int r, k, idle;
    apply_reset();
    idle = 0;
    for (int i = 0; i < 400; i++) begin
      if (m_phase >= 3) begin
        idle++;
        if (idle > 3) begin apply_reset(); idle = 0; end
      end
      r = $urandom_range(0, 99);
      if (r < 2) k = 6;
      else if (r < 4) k = 7;
      else if (r < 42) k = 4;
      else if (r < 70) k = 5;
      else k = $urandom_range(0, 3);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, k);
      checks++;
      if (obs() !== exp_vec) begin
        errors++; $display("FAIL random cyc%0d: got %b want %b", cyc, obs(), exp_vec);
      end
`ifdef PC_SEQ_PERF_EN
      checks++;
      if (retired_cnt !== 16'(m_retired) || stall_cnt !== 16'(m_stalls)) begin
        errors++; $display("FAIL random_perf cyc%0d: got %0d/%0d want %0d/%0d",
                           cyc, retired_cnt, stall_cnt, m_retired, m_stalls);
      end
`endif
      model_commit();
    end
  endtask

  initial begin
    test_reset();
    test_seq_stream();
    test_call_ret();
    test_ret_underflow();
    test_call_overflow();
    test_stall();
    test_reset_in_wait();
    test_halt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
